// File: rtl/axi4_aw_arbiter_if.sv
// Bus bundle for the AW arbiter: upstream AW requests, downstream AW port and W-route outputs.
// The arbiter uses the slave modport; the environment driving it uses master.
interface axi4_aw_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4
);
  localparam int AW_W  = AXI_ID_WIDTH + AXI_USER_WIDTH + 61;
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]      s_axi4_awvalid;
  logic [NUM_REQ-1:0]      s_axi4_awready;
  logic [NUM_REQ*AW_W-1:0] s_axi4_aw_data;
  logic                    m_axi4_awvalid;
  logic                    m_axi4_awready;
  logic [AW_W-1:0]         m_axi4_aw_data;
  logic [SEL_W-1:0]        w_sel;
  logic                    w_sel_valid;
  logic                    w_sel_pop;

  modport slave (
    input  s_axi4_awvalid, s_axi4_aw_data, m_axi4_awready, w_sel_pop,
    output s_axi4_awready, m_axi4_awvalid, m_axi4_aw_data, w_sel, w_sel_valid
  );

  modport master (
    output s_axi4_awvalid, s_axi4_aw_data, m_axi4_awready, w_sel_pop,
    input  s_axi4_awready, m_axi4_awvalid, m_axi4_aw_data, w_sel, w_sel_valid
  );
endinterface

// File: rtl/axi4_aw_arbiter.sv
// Round-robin AW arbiter with a one-entry output register and a route FIFO that
// records grant order for the W-channel mux.
module axi4_aw_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_USER_WIDTH = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input logic            axi4_aclk,
  input logic            axi4_arst,
  axi4_aw_arbiter_if.slave bus
);
  // state    | meaning
  // ST_EMPTY | output register holds nothing, m_axi4_awvalid low
  // ST_FULL  | output register holds a beat awaiting downstream accept
  localparam int AW_W  = AXI_ID_WIDTH + AXI_USER_WIDTH + 61;
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [SEL_W-1:0] LAST_REQ     = SEL_W'(NUM_REQ - 1);
  localparam logic [SEL_W:0]   REQ_CNT      = (SEL_W + 1)'(NUM_REQ);
  localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t            state, state_nxt;
  logic [AW_W-1:0]   beats [NUM_REQ];
  logic [AW_W-1:0]   out_data;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  winner;
  logic [SEL_W:0]    scan_idx;
  logic              any_valid;
  logic              can_accept;
  logic              grant;

  logic [SEL_W-1:0]  route_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              fifo_full;
  logic              fifo_pop;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign beats[i] = bus.s_axi4_aw_data[i*AW_W +: AW_W];
  end

  // Search starts at ptr and wraps; the first valid requester found wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr} + (SEL_W + 1)'(k);
      if (scan_idx >= REQ_CNT) scan_idx = scan_idx - REQ_CNT;
      if (!any_valid && bus.s_axi4_awvalid[scan_idx[SEL_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = scan_idx[SEL_W-1:0];
      end
    end
  end

  // A same-cycle pop does not free a slot; full blocks acceptance regardless.
  assign fifo_full  = (count == FIFO_FULL_CNT);
  assign can_accept = ((state == ST_EMPTY) || bus.m_axi4_awready) && !fifo_full && !axi4_arst;
  assign grant      = any_valid && can_accept;

  always_comb begin
    bus.s_axi4_awready = '0;
    if (grant) bus.s_axi4_awready[winner] = 1'b1;
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) state <= ST_EMPTY;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (grant) state_nxt = ST_FULL;
      ST_FULL: begin
        if (grant)                   state_nxt = ST_FULL;
        else if (bus.m_axi4_awready) state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      out_data <= '0;
      ptr      <= '0;
    end else if (grant) begin
      out_data <= beats[winner];
      ptr      <= (winner == LAST_REQ) ? '0 : winner + 1'b1;
    end
  end

  assign bus.m_axi4_awvalid = (state == ST_FULL);
  assign bus.m_axi4_aw_data = out_data;

  assign fifo_pop = bus.w_sel_pop && (count != '0);

  always_ff @(posedge axi4_aclk) begin
    if (grant) route_mem[wr_ptr] <= winner;
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant)    wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({grant, fifo_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.w_sel_valid = (count != '0);
  assign bus.w_sel       = bus.w_sel_valid ? route_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_axi4_aw_arbiter.sv
// Self-checking bench: directed scenarios then random traffic, all compared against
// a queue-based reference model of the arbiter.
module tb_axi4_aw_arbiter;
  localparam int N    = 4;
  localparam int IDW  = 4;
  localparam int USW  = 4;
  localparam int FD   = 8;
  localparam int AW_W = IDW + USW + 61;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_aw_arbiter_if #(.NUM_REQ(N), .AXI_ID_WIDTH(IDW), .AXI_USER_WIDTH(USW)) bus ();

  axi4_aw_arbiter #(
    .NUM_REQ(N), .AXI_ID_WIDTH(IDW), .AXI_USER_WIDTH(USW), .FIFO_DEPTH(FD)
  ) dut (
    .axi4_aclk (clk),
    .axi4_arst (rst),
    .bus       (bus)
  );

  // reference model
  bit              mdl_valid;
  logic [AW_W-1:0] mdl_data;
  int              mdl_ptr;
  int              route_q[$];
  bit              after_rst;

  // stimulus for the next cycle
  logic [N-1:0]    in_v;
  logic [AW_W-1:0] in_beat [N];
  logic            in_mr, in_pop, in_rst;

  int n_checks, n_errors;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [AW_W-1:0] rand_beat();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[AW_W-1:0];
  endfunction

  task automatic cycle();
    int           w;
    bit           can;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst = in_rst;
    bus.s_axi4_awvalid = in_v;
    for (int i = 0; i < N; i++) bus.s_axi4_aw_data[i*AW_W +: AW_W] = in_beat[i];
    bus.m_axi4_awready = in_mr;
    bus.w_sel_pop      = in_pop;
    #1;
    w   = rr_pick(in_v, mdl_ptr);
    can = !in_rst && (!mdl_valid || in_mr) && (route_q.size() < FD);
    exp_rdy = '0;
    if (w >= 0 && can) exp_rdy[w] = 1'b1;
    chk("s_awready", bus.s_axi4_awready, exp_rdy);
    chk("m_awvalid", bus.m_axi4_awvalid, mdl_valid);
    if (mdl_valid || after_rst) chk("m_aw_data", bus.m_axi4_aw_data, mdl_data);
    chk("w_sel_valid", bus.w_sel_valid, route_q.size() != 0);
    if (route_q.size() != 0)  chk("w_sel", bus.w_sel, route_q[0]);
    else if (after_rst)       chk("w_sel_rst", bus.w_sel, 0);
    // advance the model to the state after this clock edge
    after_rst = in_rst;
    if (in_rst) begin
      mdl_valid = 1'b0;
      mdl_data  = '0;
      mdl_ptr   = 0;
      route_q.delete();
    end else begin
      if (in_pop && route_q.size() != 0) void'(route_q.pop_front());
      if (w >= 0 && can) begin
        mdl_valid = 1'b1;
        mdl_data  = in_beat[w];
        route_q.push_back(w);
        mdl_ptr   = (w + 1) % N;
      end else if (mdl_valid && in_mr) begin
        mdl_valid = 1'b0;
      end
    end
  endtask

  task automatic rand_beats();
    for (int i = 0; i < N; i++) in_beat[i] = rand_beat();
  endtask

  initial begin
    logic [AW_W-1:0] b;
    n_checks = 0; n_errors = 0;
    mdl_valid = 1'b0; mdl_data = '0; mdl_ptr = 0; after_rst = 1'b1;
    rst = 1'b1;
    bus.s_axi4_awvalid = '0; bus.s_axi4_aw_data = '0;
    bus.m_axi4_awready = 1'b0; bus.w_sel_pop = 1'b0;
    in_v = '0; in_mr = 1'b0; in_pop = 1'b0; in_rst = 1'b1;
    for (int i = 0; i < N; i++) in_beat[i] = '0;
    repeat (2) cycle();
    in_rst = 1'b0;

    // single request from requester 2: addr 0x100, len 3
    b = '0; b[52:21] = 32'h100; b[20:13] = 8'd3;
    in_beat[2] = b; in_v = 4'b0100; in_mr = 1'b1;
    cycle();
    chk("single_rdy", bus.s_axi4_awready, 4'b0100);
    in_v = 4'b1111; in_pop = 1'b1; rand_beats();
    cycle();
    chk("single_addr", bus.m_axi4_aw_data[52:21], 32'h100);
    chk("single_len", bus.m_axi4_aw_data[20:13], 8'd3);
    chk("single_wsel", bus.w_sel, 2);
    chk("single_ptr3", bus.s_axi4_awready, 4'b1000);

    // fairness with all requesters valid
    for (int c = 0; c < 12; c++) begin rand_beats(); cycle(); end

    // downstream backpressure then release
    in_mr = 1'b0;
    for (int c = 0; c < 6; c++) begin rand_beats(); cycle(); end
    chk("bp_rdy", bus.s_axi4_awready, 4'b0000);
    in_mr = 1'b1;
    for (int c = 0; c < 4; c++) begin rand_beats(); cycle(); end

    // drain route FIFO, then fill it without pops
    in_v = '0; in_pop = 1'b1;
    repeat (10) cycle();
    in_v = 4'b1111; in_pop = 1'b0;
    for (int c = 0; c < 10; c++) begin rand_beats(); cycle(); end
    chk("fifo_full_rdy", bus.s_axi4_awready, 4'b0000);
    in_pop = 1'b1;
    cycle();
    chk("full_pop_push", bus.s_axi4_awready, 4'b0000);
    for (int c = 0; c < 3; c++) begin rand_beats(); cycle(); end

    // pop/push concurrency across the pointer wrap
    in_v = '0;
    repeat (10) cycle();
    for (int c = 0; c < 20; c++) begin
      in_v = 4'($urandom_range(1, 15)); rand_beats(); cycle();
    end
    in_v = '0;
    repeat (4) cycle();

    // reset while FULL with three route entries outstanding
    in_v = 4'b1111; in_pop = 1'b0; in_mr = 1'b1;
    for (int c = 0; c < 3; c++) begin rand_beats(); cycle(); end
    in_mr = 1'b0;
    cycle();
    in_rst = 1'b1;
    cycle();
    in_rst = 1'b0; in_mr = 1'b1; rand_beats();
    cycle();
    chk("rst_vld", bus.m_axi4_awvalid, 1'b0);
    chk("rst_wsel_vld", bus.w_sel_valid, 1'b0);
    chk("rst_first_grant", bus.s_axi4_awready, 4'b0001);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      in_v   = 4'($urandom_range(0, 15));
      in_mr  = ($urandom_range(0, 3) != 0);
      in_pop = ($urandom_range(0, 2) != 0);
      in_rst = ($urandom_range(0, 199) == 0);
      rand_beats();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
